// File: rtl/ram_pkg.sv
// ram_pkg: shared types and sizes for the ram bus sequencer and the ram block.
//  M      data bus width
//  A      address width
//  DEPTH  number of implemented ram locations (0..DEPTH-1), DEPTH <= 2**A
//  state_t  sequencer states
package ram_pkg;

    localparam int unsigned M     = 8;
    localparam int unsigned A     = 7;
    localparam int unsigned DEPTH = 69;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_SETUP,
        R_SAMPLE,
        R_TURN,
        ERR
    } state_t;

    // States in which this side owns the shared data bus.
    function automatic logic is_write_state(input state_t s);
        return (s == W_SETUP) || (s == W_STROBE) || (s == W_HOLD);
    endfunction

    // States in which the ram is selected.
    function automatic logic is_ram_state(input state_t s);
        return is_write_state(s) || (s == R_SETUP) || (s == R_SAMPLE);
    endfunction

endpackage

// File: rtl/ram_bus_drv.sv
// ram_bus_drv: registered output enable plus W-bit tristate driver for the shared bus.
//  clk         in    clock
//  rst         in    synchronous active-high reset (releases the bus)
//  drive_next  in    enable value to take effect after the next edge
//  wdata       in    value driven onto the bus while enabled
//  data        inout shared data bus
module ram_bus_drv #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         drive_next,
    input  logic [W-1:0] wdata,
    inout  wire  [W-1:0] data
);

    logic drive_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drive_q <= 1'b0;
        end else begin
            drive_q <= drive_next;
        end
    end

    assign data = drive_q ? wdata : {W{1'bz}};

endmodule

// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: sequences one read or write request at a time onto the ram block.
//  clk1, rst            clock and synchronous active-high reset
//  req_valid/req_ready  request handshake (ready only in IDLE)
//  req_we/addr/wdata    request fields, latched at accept
//  rsp_valid            one-cycle completion pulse
//  rsp_rdata/rsp_err    read data (0 on writes/errors) and out-of-range flag
//  address_r, writeEn, act_ram, d   registered ram controls (d = write strobe)
//  data                 shared tristate bus with the ram
// Widths and depth come from ram_pkg (M, A, DEPTH).
// Timing: the response pulse appears in the IDLE cycle four cycles after accept for
// both reads and writes; a read spends R_TURN with act_ram low so the bus is released
// for at least one full cycle before any following write drives it.
module ram_bus_ctrl
    import ram_pkg::*;
(
    input  logic         clk1,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [A-1:0] req_addr,
    input  logic [M-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [M-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic [A-1:0] address_r,
    output logic         writeEn,
    output logic         act_ram,
    output logic         d,
    inout  wire  [M-1:0] data
);

    state_t       state_q, state_d;
    logic [M-1:0] wdata_q, wdata_d;
    logic         accept;
    logic         addr_ok;

    logic         act_ram_d;
    logic         write_en_d;
    logic         d_d;
    logic         drive_d;
    logic [A-1:0] address_d;
    logic         rsp_valid_d;
    logic         rsp_err_d;
    logic [M-1:0] rsp_rdata_d;

    assign addr_ok = 32'(req_addr) < DEPTH;

    // State register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!addr_ok) begin
                        state_d = ERR;
                    end else if (req_we) begin
                        state_d = W_SETUP;
                    end else begin
                        state_d = R_SETUP;
                    end
                end
            end
            W_SETUP:  state_d = W_STROBE;
            W_STROBE: state_d = W_HOLD;
            W_HOLD:   state_d = IDLE;
            R_SETUP:  state_d = R_SAMPLE;
            R_SAMPLE: state_d = R_TURN;
            R_TURN:   state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output logic: ram controls follow the state being entered so they are registered
    // alongside it; responses are issued on leaving the last state of an access.
    always_comb begin
        req_ready   = (state_q == IDLE);
        accept      = req_valid && (state_q == IDLE);

        act_ram_d   = is_ram_state(state_d);
        write_en_d  = is_write_state(state_d);
        d_d         = (state_d == W_STROBE);
        drive_d     = is_write_state(state_d);

        address_d   = address_r;
        wdata_d     = wdata_q;
        if (accept && addr_ok) begin
            address_d = req_addr;
            wdata_d   = req_wdata;
        end

        rsp_valid_d = (state_q == W_HOLD) || (state_q == R_TURN) || (state_q == ERR);
        rsp_err_d   = (state_q == ERR);
        rsp_rdata_d = rsp_rdata;
        if (state_q == R_SAMPLE) begin
            rsp_rdata_d = data;
        end else if ((state_q == W_HOLD) || (state_q == ERR)) begin
            rsp_rdata_d = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk1) begin
        if (rst) begin
            act_ram   <= 1'b0;
            writeEn   <= 1'b0;
            d         <= 1'b0;
            address_r <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            act_ram   <= act_ram_d;
            writeEn   <= write_en_d;
            d         <= d_d;
            address_r <= address_d;
            wdata_q   <= wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

    ram_bus_drv #(
        .W (M)
    ) u_drv (
        .clk        (clk1),
        .rst        (rst),
        .drive_next (drive_d),
        .wdata      (wdata_q),
        .data       (data)
    );

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// tb_ram_bus_ctrl: directed bench for ram_bus_ctrl with a behavioural ram on the bus and
// a per-cycle expectation timeline built from each accepted request.
module tb_ram_bus_ctrl;
    import ram_pkg::*;

    localparam int NCYC = 300;

    logic         clk1 = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [A-1:0] req_addr;
    logic [M-1:0] req_wdata;
    logic         rsp_valid;
    logic [M-1:0] rsp_rdata;
    logic         rsp_err;
    logic [A-1:0] address_r;
    logic         writeEn;
    logic         act_ram;
    logic         d;
    wire  [M-1:0] data;

    ram_bus_ctrl dut (
        .clk1      (clk1),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .address_r (address_r),
        .writeEn   (writeEn),
        .act_ram   (act_ram),
        .d         (d),
        .data      (data)
    );

    always #5 clk1 = ~clk1;

    // Behavioural ram: drives the bus while selected for reading, writes on strobe.
    logic [M-1:0] ram_mem [0:127];
    assign data = (act_ram && !writeEn) ? ram_mem[address_r] : {M{1'bz}};
    always @(posedge clk1) begin
        if (act_ram && writeEn && d) ram_mem[address_r] <= data;
    end

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected timeline, one entry per cycle.
    bit           e_ready [NCYC];
    bit           e_act   [NCYC];
    bit           e_we    [NCYC];
    bit           e_d     [NCYC];
    bit           e_drv   [NCYC];
    bit           e_rv    [NCYC];
    bit           e_err   [NCYC];
    logic [M-1:0] e_rd    [NCYC];
    logic [A-1:0] e_addr  [NCYC];
    logic [M-1:0] e_wd    [NCYC];
    logic [M-1:0] m_mem   [0:127];
    int           free_c;

    function automatic void clear_from(input int c);
        for (int i = c; i < NCYC; i++) begin
            e_ready[i] = 1'b1; e_act[i] = 1'b0; e_we[i] = 1'b0; e_d[i] = 1'b0;
            e_drv[i] = 1'b0; e_rv[i] = 1'b0; e_err[i] = 1'b0; e_rd[i] = '0;
            e_addr[i] = '0; e_wd[i] = '0;
        end
    endfunction

    // Request presented in cycle a and accepted at the edge ending it.
    function automatic void sched(input int a, input bit we, input logic [A-1:0] addr,
                                  input logic [M-1:0] wd);
        if (int'(addr) >= int'(DEPTH)) begin
            e_ready[a+1] = 1'b0;
            e_rv[a+2] = 1'b1; e_err[a+2] = 1'b1; e_rd[a+2] = '0;
            free_c = a + 2;
        end else begin
            for (int k = 1; k <= 3; k++) e_ready[a+k] = 1'b0;
            for (int k = 1; k <= (we ? 3 : 2); k++) begin
                e_act[a+k] = 1'b1; e_we[a+k] = we; e_drv[a+k] = we;
                e_addr[a+k] = addr; e_wd[a+k] = wd;
            end
            if (we) begin
                e_d[a+2] = 1'b1;
                m_mem[addr] = wd;
                e_rd[a+4] = '0;
            end else begin
                e_rd[a+4] = m_mem[addr];
            end
            e_rv[a+4] = 1'b1; e_err[a+4] = 1'b0;
            free_c = a + 4;
        end
    endfunction

    // Per-cycle observations.
    bit           act_log [NCYC];
    bit           drv_log [NCYC];
    int           d_cnt = 0;
    int           rsp_cyc [$];
    logic [M-1:0] rsp_rd  [$];
    bit           rsp_e   [$];

    always @(negedge clk1) begin
        if (chk_en && cyc < NCYC) begin
            act_log[cyc] = act_ram;
            drv_log[cyc] = dut.u_drv.drive_q;
            if (d) d_cnt++;
            if (rsp_valid) begin
                rsp_cyc.push_back(cyc);
                rsp_rd.push_back(rsp_rdata);
                rsp_e.push_back(rsp_err);
            end
            check("req_ready", 32'(req_ready), 32'(e_ready[cyc]));
            check("act_ram", 32'(act_ram), 32'(e_act[cyc]));
            check("writeEn", 32'(writeEn), 32'(e_we[cyc]));
            check("d", 32'(d), 32'(e_d[cyc]));
            check("bus_drive", 32'(dut.u_drv.drive_q), 32'(e_drv[cyc]));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rv[cyc]));
            if (e_act[cyc]) check("address_r", 32'(address_r), 32'(e_addr[cyc]));
            if (e_drv[cyc]) check("bus_data", 32'(data), 32'(e_wd[cyc]));
            if (e_rv[cyc]) begin
                check("rsp_err", 32'(rsp_err), 32'(e_err[cyc]));
                check("rsp_rdata", 32'(rsp_rdata), 32'(e_rd[cyc]));
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk1);
    endtask

    task automatic do_req(input bit we, input logic [A-1:0] addr, input logic [M-1:0] wd,
                          output int acc);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        acc = (cyc > free_c) ? cyc : free_c;
        sched(acc, we, addr, wd);
        while (cyc <= acc) @(negedge clk1);
    endtask

    task automatic drop();
        req_valid = 1'b0; req_we = 1'b1; req_addr = 7'h2a; req_wdata = 8'hee;
    endtask

    task automatic get_rsp(input string name, input int exp_cyc, input logic [M-1:0] exp_rd,
                           input bit exp_err);
        check({name, "_present"}, 32'(rsp_cyc.size() > 0), 32'd1);
        if (rsp_cyc.size() > 0) begin
            check({name, "_cycle"}, 32'(rsp_cyc.pop_front()), 32'(exp_cyc));
            check({name, "_rdata"}, 32'(rsp_rd.pop_front()), 32'(exp_rd));
            check({name, "_err"}, 32'(rsp_e.pop_front()), 32'(exp_err));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, a2, d0, cnt;
        for (int i = 0; i < 128; i++) begin
            ram_mem[i] <= 8'(i) ^ 8'h5a;
            m_mem[i] = 8'(i) ^ 8'h5a;
        end
        clear_from(0);
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        chk_en = 1'b1;
        check("rst_act_ram", 32'(act_ram), 32'd0);
        check("rst_writeEn", 32'(writeEn), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_bus", 32'(dut.u_drv.drive_q), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_addr", 32'(address_r), 32'd0);
        rst = 1'b0;
        free_c = cyc;

        // Write 0xA5 @5, then read it back.
        d0 = d_cnt;
        do_req(1'b1, 7'd5, 8'ha5, a);
        drop();
        wait_to(a + 5);
        get_rsp("wr5", a + 4, 8'h00, 1'b0);
        check("wr5_d_pulses", 32'(d_cnt - d0), 32'd1);
        do_req(1'b0, 7'd5, 8'h00, a);
        drop();
        wait_to(a + 5);
        get_rsp("rd5", a + 4, 8'ha5, 1'b0);

        // Back-to-back with req_valid held; read's wdata field must not leak into the write.
        do_req(1'b1, 7'd0, 8'h3c, a);
        do_req(1'b0, 7'd0, 8'hff, a2);
        drop();
        wait_to(a2 + 5);
        get_rsp("b2b_wr", a + 4, 8'h00, 1'b0);
        get_rsp("b2b_rd", a2 + 4, 8'h3c, 1'b0);

        // Read then write, held: released bus gap before the write drives.
        do_req(1'b0, 7'd7, 8'h11, a);
        do_req(1'b1, 7'd9, 8'h81, a2);
        drop();
        wait_to(a2 + 5);
        cnt = 0;
        for (int i = a + 1; i <= a2; i++) if (!act_log[i] && !drv_log[i]) cnt++;
        check("rd_wr_gap", 32'(cnt >= 1), 32'd1);
        get_rsp("rw_rd", a + 4, 8'h5d, 1'b0);
        get_rsp("rw_wr", a2 + 4, 8'h00, 1'b0);

        // Out of range, framed by reads of location 68.
        do_req(1'b0, 7'd68, 8'h00, a);
        drop();
        wait_to(a + 5);
        get_rsp("rd68_a", a + 4, 8'h1e, 1'b0);
        do_req(1'b0, 7'd69, 8'h00, a);
        drop();
        wait_to(a + 3);
        cnt = 0;
        for (int i = a + 1; i <= a + 2; i++) if (act_log[i]) cnt++;
        check("err69_noact", 32'(cnt), 32'd0);
        get_rsp("err69", a + 2, 8'h00, 1'b1);
        do_req(1'b1, 7'd127, 8'hff, a);
        drop();
        wait_to(a + 3);
        cnt = 0;
        for (int i = a + 1; i <= a + 2; i++) if (act_log[i]) cnt++;
        check("err127_noact", 32'(cnt), 32'd0);
        get_rsp("err127", a + 2, 8'h00, 1'b1);
        do_req(1'b0, 7'd68, 8'h00, a);
        drop();
        wait_to(a + 5);
        get_rsp("rd68_b", a + 4, 8'h1e, 1'b0);

        // Reset during the write strobe.
        do_req(1'b1, 7'd20, 8'h77, a);
        drop();
        wait_to(a + 2);
        check("strobe_d", 32'(d), 32'd1);
        rst = 1'b1;
        clear_from(a + 3);
        free_c = a + 3;
        @(negedge clk1);
        rst = 1'b0;
        check("rst_mid_d", 32'(d), 32'd0);
        check("rst_mid_act", 32'(act_ram), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        wait_to(a + 7);
        check("rst_mid_norsp", 32'(rsp_cyc.size()), 32'd0);

        // Other locations survive the interrupted write.
        do_req(1'b0, 7'd5, 8'h00, a);
        drop();
        wait_to(a + 5);
        get_rsp("rd5_after", a + 4, 8'ha5, 1'b0);
        wait_to(a + 8);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
